mem_addr_unit: RTL and testbench

MEM_ADDR_UNIT -- requirements
Module: mem_addr_unit

---
 rtl/mem_addr_unit_pkg.sv | 18 +
 rtl/mem_counter.sv | 38 +++
 rtl/mem_addr_unit.sv | 146 ++++++++++++++
 tb/tb_mem_addr_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_addr_unit_pkg.sv
// Shared constants for the memory address unit: stack page, register reset
// values and the instruction-register fetch slot indices.
package mem_addr_unit_pkg;

    localparam logic [7:0]  STACK_PAGE = 8'hFF;
    localparam logic [15:0] PC_RESET   = 16'h0000;
    localparam logic [7:0]  SP_RESET   = 8'h00;

    localparam logic [1:0] FETCH_OPCODE = 2'd0;
    localparam logic [1:0] FETCH_IMM_LO = 2'd1;
    localparam logic [1:0] FETCH_IMM_HI = 2'd2;

    // Fetch slot sequence opcode -> immLo -> immHi -> opcode.
    function automatic logic [1:0] next_fetch_idx(input logic [1:0] idx);
        return (idx == FETCH_IMM_HI) ? FETCH_OPCODE : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mem_counter.sv
// Loadable up/down counter used for both the program counter and the stack
// pointer.
// Ports:
//   clk, rst   clock and asynchronous active-high reset (to RESET_VAL)
//   en         update enable; nothing changes while low
//   load       when enabled, take load_val instead of counting
//   load_val   parallel load value
//   up         count direction when enabled and not loading (1 = +1, 0 = -1)
//   count      current value
module mem_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RESET_VAL;
        end else if (en) begin
            if (load)
                count <= load_val;
            else if (up)
                count <= count + ONE;
            else
                count <= count - ONE;
        end
    end

endmodule

// File: rtl/mem_addr_unit.sv
// Memory address unit: instruction register with 3-byte fetch, program
// counter, full-descending stack pointer in page 0xFF, 16-bit memory address
// register, and the RAM address / data bus multiplexing around them.
// Ports:
//   i_clk, i_reset, i_halt     clock, async active-high reset, state freeze
//   i_bus / o_bus, o_busNOE    shared data bus in/out, low = unit drives bus
//   i_ctrl*                    control strobes (N suffix = active low)
//   o_ramAddr/Data/NWE/NOE     RAM interface, i_ramData read data
//   o_instrCode, o_imm, o_pc, o_sp, o_dbgFetchIdx   observation outputs
import mem_addr_unit_pkg::*;

module mem_addr_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_halt,
    input  logic [7:0]  i_bus,
    output logic [7:0]  o_bus,
    output logic        o_busNOE,
    input  logic        i_ctrlMemPCLoadN,
    input  logic        i_ctrlMemPCNEn,
    input  logic        i_ctrlMemSPNEn,
    input  logic        i_ctrlMemInstrNWE,
    input  logic        i_ctrlMemInstrNOE,
    input  logic        i_ctrlMemMar0NWE,
    input  logic        i_ctrlMemMar1NWE,
    input  logic        i_ctrlMemRamNWE,
    input  logic        i_ctrlMemRamNOE,
    input  logic        i_ctrlMemPCToRamN,
    input  logic        i_ctrlInstrFinishedN,
    input  logic        i_ctrlMemPCFromImm,
    input  logic        i_ctrlMemSPUp,
    input  logic        i_ctrlMemInstrImmToRamAddr,
    output logic [15:0] o_ramAddr,
    output logic [7:0]  o_ramData,
    input  logic [7:0]  i_ramData,
    output logic        o_ramNWE,
    output logic        o_ramNOE,
    output logic [7:0]  o_instrCode,
    output logic [15:0] o_imm,
    output logic [15:0] o_pc,
    output logic [7:0]  o_sp,
    output logic [1:0]  o_dbgFetchIdx
);

    logic [7:0]  opcode;
    logic [7:0]  imm_lo;
    logic [7:0]  imm_hi;
    logic [1:0]  fetch_idx;
    logic [7:0]  mar0;
    logic [7:0]  mar1;
    logic [15:0] mar;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [7:0]  sp_dec;

    assign mar    = {mar1, mar0};
    assign imm    = {imm_hi, imm_lo};
    assign sp_dec = sp - 8'd1;

    // Instruction register and fetch index. An instruction-finished strobe
    // restarts the fetch at the opcode slot but does not block a write.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            opcode    <= 8'h00;
            imm_lo    <= 8'h00;
            imm_hi    <= 8'h00;
            fetch_idx <= FETCH_OPCODE;
        end else if (!i_halt) begin
            if (!i_ctrlMemInstrNWE) begin
                case (fetch_idx)
                    FETCH_OPCODE: opcode <= i_ramData;
                    FETCH_IMM_LO: imm_lo <= i_ramData;
                    default:      imm_hi <= i_ramData;
                endcase
            end
            if (!i_ctrlInstrFinishedN)
                fetch_idx <= FETCH_OPCODE;
            else if (!i_ctrlMemInstrNWE)
                fetch_idx <= next_fetch_idx(fetch_idx);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mar0 <= 8'h00;
            mar1 <= 8'h00;
        end else if (!i_halt) begin
            if (!i_ctrlMemMar0NWE)
                mar0 <= i_bus;
            if (!i_ctrlMemMar1NWE)
                mar1 <= i_bus;
        end
    end

    mem_counter #(
        .WIDTH     (16),
        .RESET_VAL (PC_RESET)
    ) u_pc (
        .clk      (i_clk),
        .rst      (i_reset),
        .en       (!i_halt && !i_ctrlMemPCNEn),
        .load     (!i_ctrlMemPCLoadN),
        .load_val (i_ctrlMemPCFromImm ? imm : mar),
        .up       (1'b1),
        .count    (pc)
    );

    // SP points at the last pushed byte: push pre-decrements, pop post-increments.
    mem_counter #(
        .WIDTH     (8),
        .RESET_VAL (SP_RESET)
    ) u_sp (
        .clk      (i_clk),
        .rst      (i_reset),
        .en       (!i_halt && !i_ctrlMemSPNEn),
        .load     (1'b0),
        .load_val (8'h00),
        .up       (i_ctrlMemSPUp),
        .count    (sp)
    );

    always_comb begin
        o_ramAddr = mar;
        if (!i_ctrlMemPCToRamN)
            o_ramAddr = pc;
        else if (!i_ctrlMemSPNEn)
            o_ramAddr = {STACK_PAGE, (i_ctrlMemSPUp ? sp : sp_dec)};
        else if (i_ctrlMemInstrImmToRamAddr)
            o_ramAddr = imm;
    end

    assign o_ramData = i_bus;
    assign o_ramNWE  = i_ctrlMemRamNWE;
    assign o_ramNOE  = i_ctrlMemRamNOE;

    assign o_bus    = !i_ctrlMemRamNOE ? i_ramData : imm_lo;
    assign o_busNOE = i_ctrlMemRamNOE & i_ctrlMemInstrNOE;

    assign o_instrCode   = opcode;
    assign o_imm         = imm;
    assign o_pc          = pc;
    assign o_sp          = sp;
    assign o_dbgFetchIdx = fetch_idx;

endmodule

// File: tb/tb_mem_addr_unit.sv
// Directed bench for mem_addr_unit with hand-computed expected values.
module tb_mem_addr_unit;

    logic        clk;
    logic        reset;
    logic        halt;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_noe;
    logic        pc_load_n, pc_n_en, sp_n_en, instr_nwe, instr_noe;
    logic        mar0_nwe, mar1_nwe, ram_nwe, ram_noe, pc_to_ram_n, finished_n;
    logic        pc_from_imm, sp_up, imm_to_ram;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        ram_nwe_o, ram_noe_o;
    logic [7:0]  instr_code;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [1:0]  fetch_idx;

    int checks = 0;
    int errors = 0;

    mem_addr_unit dut (
        .i_clk                      (clk),
        .i_reset                    (reset),
        .i_halt                     (halt),
        .i_bus                      (bus_in),
        .o_bus                      (bus_out),
        .o_busNOE                   (bus_noe),
        .i_ctrlMemPCLoadN           (pc_load_n),
        .i_ctrlMemPCNEn             (pc_n_en),
        .i_ctrlMemSPNEn             (sp_n_en),
        .i_ctrlMemInstrNWE          (instr_nwe),
        .i_ctrlMemInstrNOE          (instr_noe),
        .i_ctrlMemMar0NWE           (mar0_nwe),
        .i_ctrlMemMar1NWE           (mar1_nwe),
        .i_ctrlMemRamNWE            (ram_nwe),
        .i_ctrlMemRamNOE            (ram_noe),
        .i_ctrlMemPCToRamN          (pc_to_ram_n),
        .i_ctrlInstrFinishedN       (finished_n),
        .i_ctrlMemPCFromImm         (pc_from_imm),
        .i_ctrlMemSPUp              (sp_up),
        .i_ctrlMemInstrImmToRamAddr (imm_to_ram),
        .o_ramAddr                  (ram_addr),
        .o_ramData                  (ram_wdata),
        .i_ramData                  (ram_rdata),
        .o_ramNWE                   (ram_nwe_o),
        .o_ramNOE                   (ram_noe_o),
        .o_instrCode                (instr_code),
        .o_imm                      (imm),
        .o_pc                       (pc),
        .o_sp                       (sp),
        .o_dbgFetchIdx              (fetch_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        halt        = 1'b0;
        pc_load_n   = 1'b1;
        pc_n_en     = 1'b1;
        sp_n_en     = 1'b1;
        instr_nwe   = 1'b1;
        instr_noe   = 1'b1;
        mar0_nwe    = 1'b1;
        mar1_nwe    = 1'b1;
        ram_nwe     = 1'b1;
        ram_noe     = 1'b1;
        pc_to_ram_n = 1'b1;
        finished_n  = 1'b1;
        pc_from_imm = 1'b0;
        sp_up       = 1'b0;
        imm_to_ram  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset     = 1'b1;
        bus_in    = 8'h00;
        ram_rdata = 8'h00;
        #12;
        check("rst_pc", pc, 16'h0000);
        check("rst_sp", sp, 8'h00);
        check("rst_imm", imm, 16'h0000);
        check("rst_op", instr_code, 8'h00);
        check("rst_idx", fetch_idx, 2'd0);
        check("rst_addr", ram_addr, 16'h0000);
        check("rst_busnoe", bus_noe, 1'b1);
        reset = 1'b0;

        // Three-byte fetch
        instr_nwe = 1'b0;
        ram_rdata = 8'h12; tick();
        check("fetch1_idx", fetch_idx, 2'd1);
        check("fetch1_op", instr_code, 8'h12);
        ram_rdata = 8'h34; tick();
        ram_rdata = 8'h56; tick();
        instr_nwe = 1'b1;
        check("fetch_op", instr_code, 8'h12);
        check("fetch_imm", imm, 16'h5634);
        check("fetch_idx", fetch_idx, 2'd0);

        // Bus output muxing
        instr_noe = 1'b0; #1;
        check("bus_immlo", bus_out, 8'h34);
        check("busnoe_instr", bus_noe, 1'b0);
        ram_noe = 1'b0; ram_rdata = 8'hAA; #1;
        check("bus_ram_wins", bus_out, 8'hAA);
        check("ramnoe_pass", ram_noe_o, 1'b0);
        instr_noe = 1'b1; ram_noe = 1'b1; #1;
        check("busnoe_idle", bus_noe, 1'b1);
        bus_in = 8'h5A; ram_nwe = 1'b0; #1;
        check("ramdata", ram_wdata, 8'h5A);
        check("ramnwe_pass", ram_nwe_o, 1'b0);
        ram_nwe = 1'b1;

        // Address priority
        imm_to_ram = 1'b1; #1;
        check("addr_imm", ram_addr, 16'h5634);
        sp_n_en = 1'b0; sp_up = 1'b1; #1;
        check("addr_stack_over_imm", ram_addr, 16'hFF00);
        pc_to_ram_n = 1'b0; #1;
        check("addr_pc_over_all", ram_addr, 16'h0000);
        idle();

        // MAR loads and PC loads
        bus_in = 8'h20; mar0_nwe = 1'b0; tick(); mar0_nwe = 1'b1;
        bus_in = 8'h10; mar1_nwe = 1'b0; tick(); mar1_nwe = 1'b1;
        check("addr_mar", ram_addr, 16'h1020);
        pc_load_n = 1'b0; pc_n_en = 1'b0; pc_from_imm = 1'b0; tick();
        check("pc_from_mar", pc, 16'h1020);
        pc_from_imm = 1'b1; tick();
        check("pc_from_imm", pc, 16'h5634);
        idle();
        pc_to_ram_n = 1'b0; #1;
        check("addr_pc", ram_addr, 16'h5634);
        pc_to_ram_n = 1'b1;

        // Both MAR bytes in one edge, then PC wrap
        bus_in = 8'hFF; mar0_nwe = 1'b0; mar1_nwe = 1'b0; tick(); idle();
        check("mar_both", ram_addr, 16'hFFFF);
        pc_load_n = 1'b0; pc_n_en = 1'b0; tick();
        check("pc_ffff", pc, 16'hFFFF);
        pc_load_n = 1'b1; tick();
        check("pc_wrap", pc, 16'h0000);
        tick();
        check("pc_inc", pc, 16'h0001);
        pc_n_en = 1'b1; tick();
        check("pc_hold", pc, 16'h0001);

        // Stack push/pop with wrap
        sp_n_en = 1'b0; sp_up = 1'b0; #1;
        check("push_addr0", ram_addr, 16'hFFFF);
        tick();
        check("push_sp0", sp, 8'hFF);
        sp_up = 1'b1; #1;
        check("pop_addr0", ram_addr, 16'hFFFF);
        tick();
        check("pop_sp0", sp, 8'h00);
        sp_up = 1'b0; tick();
        #1;
        check("push2_addr", ram_addr, 16'hFFFE);
        tick();
        check("push2_sp", sp, 8'hFE);
        sp_up = 1'b1; tick(); tick();
        check("pop2_sp", sp, 8'h00);
        idle();

        // Halt freezes a finishing write; then the same edge without halt
        instr_nwe = 1'b0; ram_rdata = 8'h9A; tick();
        check("pre_idx", fetch_idx, 2'd1);
        halt = 1'b1; finished_n = 1'b0; ram_rdata = 8'hBC;
        pc_n_en = 1'b0; sp_n_en = 1'b0; sp_up = 1'b0; #1;
        check("halt_addr_live", ram_addr, 16'hFFFF);
        tick();
        check("halt_imm", imm, 16'h5634);
        check("halt_idx", fetch_idx, 2'd1);
        check("halt_op", instr_code, 8'h9A);
        check("halt_pc", pc, 16'h0001);
        check("halt_sp", sp, 8'h00);
        idle();
        instr_nwe = 1'b0; finished_n = 1'b0; ram_rdata = 8'hBC; tick(); idle();
        check("fin_imm", imm, 16'h56BC);
        check("fin_idx", fetch_idx, 2'd0);
        check("fin_op", instr_code, 8'h9A);

        // Asynchronous reset mid-cycle, mid-fetch
        bus_in = 8'h34; mar0_nwe = 1'b0; tick(); mar0_nwe = 1'b1;
        bus_in = 8'h12; mar1_nwe = 1'b0; tick(); mar1_nwe = 1'b1;
        pc_load_n = 1'b0; pc_n_en = 1'b0; tick(); idle();
        check("pc_1234", pc, 16'h1234);
        instr_nwe = 1'b0; ram_rdata = 8'h77; tick(); instr_nwe = 1'b1;
        check("mid_idx", fetch_idx, 2'd1);
        halt = 1'b1; #3;
        reset = 1'b1; #1;
        check("arst_pc", pc, 16'h0000);
        check("arst_idx", fetch_idx, 2'd0);
        check("arst_op", instr_code, 8'h00);
        check("arst_imm", imm, 16'h0000);
        check("arst_addr", ram_addr, 16'h0000);
        #1;
        reset = 1'b0; halt = 1'b0;
        pc_n_en = 1'b0; pc_load_n = 1'b1; tick(); idle();
        check("post_rst_pc", pc, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
